param_rs: RTL and testbench
===========================

// Module: param_rs
// PURPOSE
//  Parametrised reservation station, the successor to the fixed ALU RS inside the issue stage.
//  Buffers renamed instructions from dispatch and snoops the CDB to capture source operands.
//  Issues up to ISSUE_W ready instructions per cycle to the attached functional units.
//  One instance replaces the ALU RS and backs the future MDU RS.
// PARAMETERS
//  DEPTH       8           entries (power of 2, >=2)
//  DISPATCH_W  PIPE_WIDTH  dispatch write ports per cycle
//  ISSUE_W     2           issue ports / FUs served
//  CDB_W       PIPE_WIDTH  CDB broadcast ports snooped
// PORTS
//  clk         in   1                    clock
//  rst         in   1                    synchronous, active-high reset
//  flush       in   1                    squash all entries (sync)
//  rs_rdy      out  DISPATCH_W           rs_rdy[i]=1 iff free entries > i
//  rs_we       in   DISPATCH_W           per-port write enable
//  rs_entry    in   instruction_t[DISPATCH_W]  renamed instr; operands carry is_renamed/tag/data
//  fu_rdy      in   ISSUE_W              FU k accepts a packet this cycle
//  fu_packets  out  instruction_t[ISSUE_W]     issued instr, operands resolved; .valid marks it
//  cdb_ports   in   writeback_packet_t[CDB_W]  result broadcasts (valid, dest_tag, result)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On rst: all entries invalid, rs_rdy all 1,
//    every fu_packets[k].valid=0. Age state is cleared.
//  - Entry state: valid, instr, per-operand rdy (=~is_renamed at write), age info.
//  - rs_rdy is combinational from current occupancy only. Frees in the same cycle do not count.
//  - Allocation:
//    - A port with rs_we[i]&rs_rdy[i] writes the lowest-index free entry not taken by a lower port.
//    - Gaps in rs_we are allowed.
//    - rs_we[i] with rs_rdy[i]=0 is ignored; the bench flags it as a protocol error.
//  - Wakeup:
//    - Each cycle, every valid CDB port whose dest_tag equals a non-ready operand tag writes result
//      into data and sets rdy.
//    - This applies to resident entries and to entries being written this cycle (same-cycle bypass).
//    - Multiple CDB matches on one tag cannot legally occur; the lowest CDB port wins.
//  - Select:
//    - An entry is eligible iff valid and both operands rdy as held in registers.
//    - An operand woken in cycle N is eligible in cycle N+1, so the minimum RS latency is 1 cycle.
//    - Pick up to ISSUE_W distinct eligible entries and drive each to fu_packets[k] combinationally.
//    - Lower k is filled first.
//    - Port k with fu_rdy[k]=0 is skipped; its candidate goes to the next ready port.
//    - fu_packets[k].valid=0 when nothing is presented.
//  - Deallocation: an entry presented on port k with fu_rdy[k]=1 is invalidated at the clock edge.
//  - Full: rs_rdy all 0 and no writes. An issue in the same cycle frees an entry visible next cycle.
//  - Empty: no packets, rs_rdy all 1.
//  - flush:
//    - Invalidates all entries at the edge and overrides rs_we and issue frees that cycle.
//    - fu_packets remain combinational and may show valid during the flush cycle; FUs ignore them
//      under flush.
//  - rst takes priority over flush; mid-operation rst discards all state in one cycle.
// CONFIGURATION
//  RS_AGE_SELECT_EN defined:
//  - A DEPTH x DEPTH age matrix records program order.
//  - On write, the new entry is younger than all valid entries.
//  - Same-cycle writes are ordered by port index, lower port older.
//  - Select is oldest-first among eligible entries.
//  RS_AGE_SELECT_EN undefined:
//  - No age matrix.
//  - Select is lowest-entry-index-first.
//  - All other behaviour is identical.
// TESTING
//  1. rst, then 3 independent instrs on ports 0..2 with fu_rdy=0.
//     -> occupancy 3; with DEPTH=8, rs_rdy all 1.
//     -> Raise fu_rdy=2'b11: two packets next cycle, the third the cycle after.
//  2. Instr with src tag 5 unready; CDB port 1 broadcasts tag 5 / 0xDEAD in cycle N.
//     -> Issued in N+1 with operand data 0xDEAD.
//     -> Same test with the broadcast in the write cycle gives the identical result.
//  3. Fill DEPTH entries, all unready.
//     -> rs_rdy=0 and writes ignored.
//     -> Wake 1 entry and issue it: rs_rdy[0]=1 the cycle after the issue.
//  4. fu_rdy=2'b10 with 1 eligible entry.
//     -> Presented on port 1; port 0 valid=0.
//  5. With RS_AGE_SELECT_EN: write A then B into lower-index slots.
//     - Write A into entry 3 and B into entry 1, both ready, ISSUE_W=1.
//     - Required order: A then B.
//     - With the macro undefined, the order is B then A.
//  6. flush with 4 resident entries and a concurrent rs_we.
//     -> Next cycle empty, rs_rdy all 1, no packets.
//     -> Repeat with rst asserted mid-wakeup: same result.

Source files
------------

// File: rtl/param_rs_if.sv
// param_rs_if: shared operand/instruction/writeback types and the
// dispatch, issue and CDB bundle that connects a param_rs instance.
package param_rs_pkg;
    localparam int PIPE_WIDTH = 3;
    localparam int XLEN       = 32;
    localparam int TAG_W      = 6;

    typedef struct packed {
        logic             is_renamed;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } operand_t;

    typedef struct packed {
        logic             valid;
        logic [7:0]       opcode;
        logic [TAG_W-1:0] dest_tag;
        operand_t         src1;
        operand_t         src2;
    } instruction_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;
endpackage

interface param_rs_if #(
    parameter int DISPATCH_W = param_rs_pkg::PIPE_WIDTH,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = param_rs_pkg::PIPE_WIDTH
);
    import param_rs_pkg::*;

    logic                            flush;
    logic              [DISPATCH_W-1:0] rs_rdy;
    logic              [DISPATCH_W-1:0] rs_we;
    instruction_t      [DISPATCH_W-1:0] rs_entry;
    logic              [ISSUE_W-1:0]    fu_rdy;
    instruction_t      [ISSUE_W-1:0]    fu_packets;
    writeback_packet_t [CDB_W-1:0]      cdb_ports;

    modport master (
        output flush, rs_we, rs_entry, fu_rdy, cdb_ports,
        input  rs_rdy, fu_packets
    );

    modport slave (
        input  flush, rs_we, rs_entry, fu_rdy, cdb_ports,
        output rs_rdy, fu_packets
    );
endinterface

// File: rtl/param_rs.sv
// param_rs: reservation station with CDB snoop and multi-port issue.
// RS_AGE_SELECT_EN enables oldest-first select via an age matrix.
module param_rs
    import param_rs_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = PIPE_WIDTH,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = PIPE_WIDTH
) (
    input logic       clk,
    input logic       rst,
    param_rs_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic         [DEPTH-1:0]      valid_q;
    logic         [DEPTH-1:0]      valid_d;
    instruction_t                  instr_q [DEPTH];
    instruction_t                  instr_d [DEPTH];
    logic         [DEPTH-1:0]      eligible;
    logic         [CNT_W-1:0]      free_cnt;
    logic         [DISPATCH_W-1:0] rdy;
    logic         [DISPATCH_W-1:0] alloc_en;
    logic         [IDX_W-1:0]      alloc_idx [DISPATCH_W];
    logic         [DEPTH-1:0]      taken;
    logic         [ISSUE_W-1:0]    sel_en;
    logic         [IDX_W-1:0]      sel_idx [ISSUE_W];
    logic         [DEPTH-1:0]      cand;
    logic         [DEPTH-1:0]      issue_clr;
    logic                          pick;
    instruction_t [ISSUE_W-1:0]    pkts;
    writeback_packet_t [CDB_W-1:0] cdb;

    assign cdb = bus.cdb_ports;

    function automatic operand_t snoop(
        input operand_t                      op,
        input writeback_packet_t [CDB_W-1:0] c
    );
        operand_t r;
        logic     hit;
        r   = op;
        hit = 1'b0;
        for (int p = 0; p < CDB_W; p++) begin
            if (!hit && op.is_renamed && c[p].valid && c[p].dest_tag == op.tag) begin
                hit          = 1'b1;
                r.is_renamed = 1'b0;
                r.data       = c[p].result;
            end
        end
        return r;
    endfunction

    always_comb begin
        free_cnt = '0;
        for (int e = 0; e < DEPTH; e++)
            free_cnt = free_cnt + {{(CNT_W-1){1'b0}}, ~valid_q[e]};
        for (int i = 0; i < DISPATCH_W; i++)
            rdy[i] = (int'(free_cnt) > i);
    end

    assign bus.rs_rdy = rdy;

    // Descending scan leaves the lowest free slot not claimed by a lower port.
    always_comb begin
        taken    = '0;
        alloc_en = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_idx[i] = '0;
            if (bus.rs_we[i] && rdy[i]) begin
                for (int e = DEPTH - 1; e >= 0; e--) begin
                    if (!valid_q[e] && !taken[e]) begin
                        alloc_en[i]  = 1'b1;
                        alloc_idx[i] = IDX_W'(e);
                    end
                end
                if (alloc_en[i])
                    taken[alloc_idx[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            eligible[e] = valid_q[e]
                        & ~instr_q[e].src1.is_renamed
                        & ~instr_q[e].src2.is_renamed;
    end

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [DEPTH-1:0][DEPTH-1:0] older_d;
    logic [DEPTH-1:0]            ahead;

    // older[i][j] set means entry i entered before entry j.
    always_comb begin
        older_d = older_q;
        ahead   = valid_q;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (alloc_en[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[alloc_idx[i]][j] = 1'b0;
                    older_d[j][alloc_idx[i]] = ahead[j];
                end
                ahead[alloc_idx[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            older_q <= '0;
        else
            older_q <= older_d;
    end
`endif

    always_comb begin
        cand      = eligible;
        sel_en    = '0;
        issue_clr = '0;
        pick      = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            sel_idx[k] = '0;
            if (bus.fu_rdy[k]) begin
                for (int e = 0; e < DEPTH; e++) begin
`ifdef RS_AGE_SELECT_EN
                    pick = cand[e]
                         && ((cand & ~older_q[e] & ~(DEPTH'(1) << e)) == '0);
`else
                    pick = cand[e];
`endif
                    if (!sel_en[k] && pick) begin
                        sel_en[k]  = 1'b1;
                        sel_idx[k] = IDX_W'(e);
                    end
                end
                if (sel_en[k]) begin
                    cand[sel_idx[k]]      = 1'b0;
                    issue_clr[sel_idx[k]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            pkts[k] = '0;
            if (sel_en[k]) begin
                pkts[k]       = instr_q[sel_idx[k]];
                pkts[k].valid = 1'b1;
            end
        end
    end

    assign bus.fu_packets = pkts;

    // Incoming entries snoop the CDB too, so a same-cycle result is not lost.
    always_comb begin
        valid_d = valid_q & ~issue_clr;
        for (int e = 0; e < DEPTH; e++) begin
            instr_d[e]      = instr_q[e];
            instr_d[e].src1 = snoop(instr_q[e].src1, cdb);
            instr_d[e].src2 = snoop(instr_q[e].src2, cdb);
        end
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (alloc_en[i]) begin
                valid_d[alloc_idx[i]]      = 1'b1;
                instr_d[alloc_idx[i]]      = bus.rs_entry[i];
                instr_d[alloc_idx[i]].valid = 1'b1;
                instr_d[alloc_idx[i]].src1 = snoop(bus.rs_entry[i].src1, cdb);
                instr_d[alloc_idx[i]].src2 = snoop(bus.rs_entry[i].src2, cdb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++)
            instr_q[e] <= instr_d[e];
    end
endmodule

// File: tb/tb_param_rs.sv
// tb_param_rs: directed scenarios plus random traffic for param_rs,
// checked every cycle against an entry-level behavioural model.
module tb_param_rs;
    import param_rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = PIPE_WIDTH;
    localparam int IW    = 2;
    localparam int CW    = PIPE_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    param_rs_if #(.DISPATCH_W(DW), .ISSUE_W(IW), .CDB_W(CW)) bus ();

    param_rs #(
        .DEPTH(DEPTH), .DISPATCH_W(DW), .ISSUE_W(IW), .CDB_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    bit           m_valid [DEPTH];
    instruction_t m_instr [DEPTH];
    int           m_seq   [DEPTH];
    int           seq_ctr;
    int           errors;
    int           checks;
    int           proto;
    instruction_t last_pk [IW];
    logic [DW-1:0] last_rdy;
    logic [7:0]   first_op;
    logic [7:0]   second_op;

    // Result for a waiting operand; scanning high to low lets the lowest port win.
    function automatic operand_t wake(input operand_t op);
        operand_t r;
        r = op;
        if (op.is_renamed) begin
            for (int p = CW - 1; p >= 0; p--) begin
                if (bus.cdb_ports[p].valid && bus.cdb_ports[p].dest_tag == op.tag) begin
                    r.is_renamed = 1'b0;
                    r.data       = bus.cdb_ports[p].result;
                end
            end
        end
        return r;
    endfunction

    function automatic int model_free();
        int n;
        n = 0;
        for (int e = 0; e < DEPTH; e++)
            if (!m_valid[e]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] model_rdy();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++)
            r[i] = (model_free() > i);
        return r;
    endfunction

    function automatic instruction_t mk(
        input logic [7:0] op,
        input bit r1, input logic [5:0] t1,
        input bit r2, input logic [5:0] t2
    );
        instruction_t x;
        x.valid           = 1'b1;
        x.opcode          = op;
        x.dest_tag        = 6'($urandom);
        x.src1.is_renamed = r1;
        x.src1.tag        = t1;
        x.src1.data       = $urandom;
        x.src2.is_renamed = r2;
        x.src2.tag        = t2;
        x.src2.data       = $urandom;
        return x;
    endfunction

    task automatic idle();
        bus.rs_we     = '0;
        bus.rs_entry  = '0;
        bus.fu_rdy    = '0;
        bus.cdb_ports = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic bcast(input int p, input logic [5:0] tag, input logic [31:0] val);
        bus.cdb_ports[p] = '{1'b1, tag, val};
    endtask

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: compare at negedge, then advance the model to the next state.
    task automatic cycle();
        logic [DW-1:0] exp_rdy;
        bit            picked [DEPTH];
        int            best;
        int            slot [DW];
        int            fq [$];
        instruction_t  exp;
        @(negedge clk);
        exp_rdy  = model_rdy();
        last_rdy = bus.rs_rdy;
        for (int k = 0; k < IW; k++)
            last_pk[k] = bus.fu_packets[k];
        if (!rst) begin
            checks++;
            assert (bus.rs_rdy === exp_rdy) else begin
                errors++;
                $error("FAIL rs_rdy observed=%b expected=%b", bus.rs_rdy, exp_rdy);
            end
        end
        for (int e = 0; e < DEPTH; e++)
            picked[e] = 1'b0;
        for (int k = 0; k < IW; k++) begin
            best = -1;
            if (bus.fu_rdy[k]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (m_valid[e] && !picked[e] && !m_instr[e].src1.is_renamed
                        && !m_instr[e].src2.is_renamed) begin
`ifdef RS_AGE_SELECT_EN
                        if (best < 0 || m_seq[e] < m_seq[best]) best = e;
`else
                        if (best < 0) best = e;
`endif
                    end
                end
            end
            if (best >= 0) picked[best] = 1'b1;
            if (!rst) begin
                checks++;
                assert (bus.fu_packets[k].valid === (best >= 0)) else begin
                    errors++;
                    $error("FAIL pkt%0d_valid observed=%b expected=%b",
                           k, bus.fu_packets[k].valid, best >= 0);
                end
                if (best >= 0) begin
                    exp       = m_instr[best];
                    exp.valid = 1'b1;
                    checks++;
                    assert (bus.fu_packets[k] === exp) else begin
                        errors++;
                        $error("FAIL pkt%0d observed=%h expected=%h",
                               k, bus.fu_packets[k], exp);
                    end
                end
            end
        end
        for (int e = 0; e < DEPTH; e++)
            if (!m_valid[e]) fq.push_back(e);
        for (int i = 0; i < DW; i++) begin
            slot[i] = -1;
            if (bus.rs_we[i]) begin
                if (exp_rdy[i]) slot[i] = fq.pop_front();
                else if (!rst && !bus.flush) proto++;
            end
        end
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
            seq_ctr = 0;
        end else if (bus.flush) begin
            for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (m_valid[e]) begin
                    m_instr[e].src1 = wake(m_instr[e].src1);
                    m_instr[e].src2 = wake(m_instr[e].src2);
                end
                if (picked[e]) m_valid[e] = 1'b0;
            end
            for (int i = 0; i < DW; i++) begin
                if (slot[i] >= 0) begin
                    m_instr[slot[i]]       = bus.rs_entry[i];
                    m_instr[slot[i]].valid = 1'b1;
                    m_instr[slot[i]].src1  = wake(bus.rs_entry[i].src1);
                    m_instr[slot[i]].src2  = wake(bus.rs_entry[i].src2);
                    m_valid[slot[i]]       = 1'b1;
                    m_seq[slot[i]]         = seq_ctr;
                    seq_ctr++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0; checks = 0; proto = 0; seq_ctr = 0;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        expect_eq("reset_rdy", 64'(last_rdy), 64'b111);
        expect_eq("reset_pk0", 64'(last_pk[0].valid), 64'd0);
        expect_eq("reset_pk1", 64'(last_pk[1].valid), 64'd0);

        // three independent instructions, held until the FUs open
        bus.rs_we       = 3'b111;
        bus.rs_entry[0] = mk(8'h01, 0, 6'd0, 0, 6'd0);
        bus.rs_entry[1] = mk(8'h02, 0, 6'd0, 0, 6'd0);
        bus.rs_entry[2] = mk(8'h03, 0, 6'd0, 0, 6'd0);
        cycle();
        idle();
        cycle();
        expect_eq("occ3_rdy", 64'(last_rdy), 64'b111);
        expect_eq("occ3_hold", 64'(last_pk[0].valid), 64'd0);
        bus.fu_rdy = 2'b11;
        cycle();
        expect_eq("t1_p0", 64'(last_pk[0].opcode), 64'h01);
        expect_eq("t1_p1", 64'(last_pk[1].opcode), 64'h02);
        cycle();
        expect_eq("t1_third", 64'(last_pk[0].opcode), 64'h03);
        expect_eq("t1_p1_idle", 64'(last_pk[1].valid), 64'd0);

        // wakeup one cycle after the write
        idle();
        bus.fu_rdy      = 2'b11;
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h20, 1, 6'd5, 0, 6'd0);
        cycle();
        bus.rs_we = '0;
        bcast(1, 6'd5, 32'hDEAD);
        cycle();
        expect_eq("t2_not_yet", 64'(last_pk[0].valid), 64'd0);
        bus.cdb_ports = '0;
        cycle();
        expect_eq("t2_issue", 64'(last_pk[0].valid), 64'd1);
        expect_eq("t2_data", 64'(last_pk[0].src1.data), 64'hDEAD);

        // broadcast in the write cycle itself
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h21, 1, 6'd5, 0, 6'd0);
        bcast(1, 6'd5, 32'hDEAD);
        cycle();
        expect_eq("t2b_not_yet", 64'(last_pk[0].valid), 64'd0);
        bus.rs_we     = '0;
        bus.cdb_ports = '0;
        cycle();
        expect_eq("t2b_issue", 64'(last_pk[0].opcode), 64'h21);
        expect_eq("t2b_data", 64'(last_pk[0].src1.data), 64'hDEAD);

        // fill every entry with waiting instructions
        idle();
        bus.rs_we = 3'b111;
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'(8'h30 + i), 1, 6'(10 + i), 0, 6'd0);
        cycle();
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'(8'h33 + i), 1, 6'(13 + i), 0, 6'd0);
        cycle();
        bus.rs_we = 3'b011;
        for (int i = 0; i < 2; i++)
            bus.rs_entry[i] = mk(8'(8'h36 + i), 1, 6'(16 + i), 0, 6'd0);
        cycle();
        bus.rs_we = 3'b111;
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'hEE, 0, 6'd0, 0, 6'd0);
        cycle();
        expect_eq("full_rdy", 64'(last_rdy), 64'b000);
        bus.rs_we = '0;
        bcast(0, 6'd12, 32'h1234);
        cycle();
        bus.cdb_ports = '0;
        bus.fu_rdy    = 2'b01;
        cycle();
        expect_eq("full_issue", 64'(last_pk[0].opcode), 64'h32);
        expect_eq("full_rdy_same", 64'(last_rdy), 64'b000);
        bus.fu_rdy = 2'b00;
        cycle();
        expect_eq("full_rdy_after", 64'(last_rdy), 64'b001);
        bus.fu_rdy = 2'b11;
        bcast(0, 6'd10, 32'hA0); bcast(1, 6'd11, 32'hA1); bcast(2, 6'd13, 32'hA3);
        cycle();
        bcast(0, 6'd14, 32'hA4); bcast(1, 6'd15, 32'hA5); bcast(2, 6'd16, 32'hA6);
        cycle();
        bus.cdb_ports = '0;
        bcast(2, 6'd17, 32'hA7);
        cycle();
        bus.cdb_ports = '0;
        for (int n = 0; n < 5; n++) cycle();
        expect_eq("drained", 64'(last_rdy), 64'b111);

        // lone eligible entry goes to the only ready port
        idle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h40, 0, 6'd0, 0, 6'd0);
        cycle();
        idle();
        bus.fu_rdy = 2'b10;
        cycle();
        expect_eq("t4_p0", 64'(last_pk[0].valid), 64'd0);
        expect_eq("t4_p1", 64'(last_pk[1].opcode), 64'h40);
        expect_eq("t4_p1v", 64'(last_pk[1].valid), 64'd1);

        // A lands in entry 3, B later in entry 1
        idle();
        bus.rs_we       = 3'b111;
        bus.rs_entry[0] = mk(8'h50, 1, 6'd20, 0, 6'd0);
        bus.rs_entry[1] = mk(8'h51, 1, 6'd21, 0, 6'd0);
        bus.rs_entry[2] = mk(8'h52, 1, 6'd22, 0, 6'd0);
        cycle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h53, 0, 6'd0, 0, 6'd0);
        cycle();
        idle();
        bus.fu_rdy = 2'b01;
        cycle();
        idle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'hAA, 0, 6'd0, 0, 6'd0);
        cycle();
        idle();
        bcast(0, 6'd21, 32'h21);
        cycle();
        idle();
        bus.fu_rdy = 2'b01;
        cycle();
        expect_eq("t5_pre", 64'(last_pk[0].opcode), 64'h51);
        idle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'hBB, 0, 6'd0, 0, 6'd0);
        cycle();
        idle();
        bus.fu_rdy = 2'b01;
        cycle();
        first_op = last_pk[0].opcode;
        cycle();
        second_op = last_pk[0].opcode;
`ifdef RS_AGE_SELECT_EN
        expect_eq("t5_first", 64'(first_op), 64'hAA);
        expect_eq("t5_second", 64'(second_op), 64'hBB);
`else
        expect_eq("t5_first", 64'(first_op), 64'hBB);
        expect_eq("t5_second", 64'(second_op), 64'hAA);
`endif
        bus.fu_rdy = 2'b11;
        bcast(0, 6'd20, 32'h20); bcast(1, 6'd22, 32'h22);
        cycle();
        bus.cdb_ports = '0;
        for (int n = 0; n < 3; n++) cycle();

        // flush with residents and a concurrent write
        idle();
        bus.rs_we = 3'b111;
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'(8'h60 + i), 1, 6'(30 + i), 0, 6'd0);
        cycle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h63, 1, 6'd33, 0, 6'd0);
        cycle();
        bus.rs_we = 3'b111;
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'h70, 0, 6'd0, 0, 6'd0);
        bus.flush = 1'b1;
        cycle();
        idle();
        bus.fu_rdy = 2'b11;
        cycle();
        expect_eq("flush_rdy", 64'(last_rdy), 64'b111);
        expect_eq("flush_pk0", 64'(last_pk[0].valid), 64'd0);
        expect_eq("flush_pk1", 64'(last_pk[1].valid), 64'd0);

        // reset in the middle of a wakeup
        idle();
        bus.rs_we = 3'b111;
        for (int i = 0; i < 3; i++)
            bus.rs_entry[i] = mk(8'(8'h80 + i), 1, 6'(30 + i), 0, 6'd0);
        cycle();
        bus.rs_we       = 3'b001;
        bus.rs_entry[0] = mk(8'h83, 1, 6'd33, 0, 6'd0);
        cycle();
        idle();
        bus.fu_rdy = 2'b11;
        bcast(0, 6'd30, 32'h30); bcast(1, 6'd31, 32'h31); bcast(2, 6'd32, 32'h32);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        bus.fu_rdy = 2'b11;
        cycle();
        expect_eq("rst_rdy", 64'(last_rdy), 64'b111);
        expect_eq("rst_pk0", 64'(last_pk[0].valid), 64'd0);
        expect_eq("rst_pk1", 64'(last_pk[1].valid), 64'd0);

        // random legal traffic
        for (int n = 0; n < 400; n++) begin
            int base;
            idle();
            bus.rs_we = 3'($urandom) & model_rdy();
            for (int i = 0; i < DW; i++)
                bus.rs_entry[i] = mk(8'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
                                     1'($urandom), 6'($urandom_range(0, 7)));
            base = $urandom_range(0, 7);
            for (int p = 0; p < CW; p++)
                if ($urandom_range(0, 1) == 1)
                    bcast(p, 6'((base + p) % 8), $urandom);
            bus.fu_rdy = 2'($urandom);
            bus.flush  = ($urandom_range(0, 39) == 0);
            cycle();
        end

        idle();
        $display("note: dispatch writes offered while rs_rdy was low = %0d", proto);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
